// File: rtl/ram_dma.sv
// Single-port RAM DMA engine: ascending word copy, plus constant fill when RAM_DMA_FILL_EN is defined.
// RAM port outputs are registered, decoded from the next state so they line up with each state.
module ram_dma (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        START,
    input  logic [7:0]  SRC,
    input  logic [7:0]  DST,
    input  logic [8:0]  LEN,
`ifdef RAM_DMA_FILL_EN
    input  logic        FILL,
    input  logic [15:0] PATTERN,
`endif
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  MEM_ADDRESS,
    output logic        MEM_LOAD,
    output logic [15:0] MEM_IN,
    input  logic [15:0] MEM_OUT
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
`ifdef RAM_DMA_FILL_EN
    logic          fill_q, fill_d;
    logic [DW-1:0] pat_q, pat_d;
`endif
    logic          busy_d, done_d, load_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef RAM_DMA_FILL_EN
        fill_d  = fill_q;
        pat_d   = pat_q;
`endif
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load_d  = 1'b0;
        addr_d  = AW'(0);
        wdata_d = DW'(0);

        case (state_q)
            IDLE: begin
                if (START) begin
                    src_d = SRC;
                    dst_d = DST;
                    cnt_d = LEN;
`ifdef RAM_DMA_FILL_EN
                    fill_d = FILL;
                    pat_d  = PATTERN;
`endif
                    if (LEN == CW'(0))
                        state_d = FIN;
`ifdef RAM_DMA_FILL_EN
                    else if (FILL)
                        state_d = WRITE;
`endif
                    else
                        state_d = READ;
                end
            end
            READ: begin
                data_d  = MEM_OUT;
                state_d = WRITE;
            end
            WRITE: begin
                src_d = src_q + AW'(1);
                dst_d = dst_q + AW'(1);
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == CW'(0))
                    state_d = FIN;
`ifdef RAM_DMA_FILL_EN
                else if (fill_q)
                    state_d = WRITE;
`endif
                else
                    state_d = READ;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Port values for the state being entered
        case (state_d)
            READ: begin
                busy_d = 1'b1;
                addr_d = src_d;
            end
            WRITE: begin
                busy_d = 1'b1;
                load_d = 1'b1;
                addr_d = dst_d;
`ifdef RAM_DMA_FILL_EN
                wdata_d = fill_d ? pat_d : data_d;
`else
                wdata_d = data_d;
`endif
            end
            FIN:     done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            src_q       <= AW'(0);
            dst_q       <= AW'(0);
            cnt_q       <= CW'(0);
            data_q      <= DW'(0);
`ifdef RAM_DMA_FILL_EN
            fill_q      <= 1'b0;
            pat_q       <= DW'(0);
`endif
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            MEM_LOAD    <= 1'b0;
            MEM_ADDRESS <= AW'(0);
            MEM_IN      <= DW'(0);
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
`ifdef RAM_DMA_FILL_EN
            fill_q      <= fill_d;
            pat_q       <= pat_d;
`endif
            BUSY        <= busy_d;
            DONE        <= done_d;
            MEM_LOAD    <= load_d;
            MEM_ADDRESS <= addr_d;
            MEM_IN      <= wdata_d;
        end
    end
endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: RAM model on the port, array-level copy/fill reference model.
module tb_ram_dma;
    logic        CLK;
    logic        RESETN;
    logic        START;
    logic [7:0]  SRC;
    logic [7:0]  DST;
    logic [8:0]  LEN;
`ifdef RAM_DMA_FILL_EN
    logic        FILL;
    logic [15:0] PATTERN;
`endif
    logic        BUSY;
    logic        DONE;
    logic [7:0]  MEM_ADDRESS;
    logic        MEM_LOAD;
    logic [15:0] MEM_IN;
    logic [15:0] MEM_OUT;

    logic [15:0] ram [256];
    logic [15:0] exp_mem [256];
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [15:0] tb_data;
    logic [7:0]  rd_q [$];
    logic [7:0]  wr_q [$];
    int          total;
    int          bad;

    ram_dma dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .START(START),
        .SRC(SRC),
        .DST(DST),
        .LEN(LEN),
`ifdef RAM_DMA_FILL_EN
        .FILL(FILL),
        .PATTERN(PATTERN),
`endif
        .BUSY(BUSY),
        .DONE(DONE),
        .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_LOAD(MEM_LOAD),
        .MEM_IN(MEM_IN),
        .MEM_OUT(MEM_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM: combinational read, write on rising edge; bench back door used only while the DMA is idle
    assign MEM_OUT = ram[MEM_ADDRESS];
    always @(posedge CLK) begin
        if (MEM_LOAD)
            ram[MEM_ADDRESS] <= MEM_IN;
        else if (tb_we)
            ram[tb_addr] <= tb_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic load_ram();
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            tb_we   = 1'b1;
            tb_addr = 8'(i);
            tb_data = exp_mem[i];
        end
        @(negedge CLK);
        tb_we = 1'b0;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'($urandom);
    endtask

    // Reference: sequential ascending word copy, addresses modulo 256
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int l);
        for (int i = 0; i < l; i++) exp_mem[8'(int'(d) + i)] = exp_mem[8'(int'(s) + i)];
    endtask

    function automatic int count_mism();
        int n = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    // Start a transfer and observe it at falling edges; cycle 1 is the first cycle after acceptance
    task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                            input int glitch_at, input int stop_at,
                            output int busy_cyc, output int done_at, output int loads,
                            output bit fin_zero);
        rd_q.delete();
        wr_q.delete();
        busy_cyc = 0;
        done_at  = 0;
        loads    = 0;
        fin_zero = 1'b0;
        @(negedge CLK);
        SRC = s;
        DST = d;
        LEN = l;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        SRC = 8'($urandom);
        DST = 8'($urandom);
        LEN = 9'($urandom);
`ifdef RAM_DMA_FILL_EN
        PATTERN = 16'($urandom);
        FILL = ~FILL;
`endif
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (BUSY) busy_cyc++;
            if (MEM_LOAD) begin
                loads++;
                wr_q.push_back(MEM_ADDRESS);
            end else if (BUSY) begin
                rd_q.push_back(MEM_ADDRESS);
            end
            if (DONE) begin
                done_at  = cyc;
                fin_zero = (MEM_ADDRESS == 8'd0) && (MEM_LOAD == 1'b0) &&
                           (MEM_IN == 16'd0) && (BUSY == 1'b0);
                break;
            end
            if (cyc == stop_at) break;
            START = (cyc == glitch_at);
            if (cyc == glitch_at) SRC = s ^ 8'h5A;
            @(negedge CLK);
        end
        START = 1'b0;
`ifdef RAM_DMA_FILL_EN
        FILL = ~FILL;
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        total++;
        if ({BUSY, DONE, MEM_LOAD, MEM_ADDRESS, MEM_IN} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {BUSY, DONE, MEM_LOAD, MEM_ADDRESS, MEM_IN});
        end
        RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({BUSY, DONE, MEM_LOAD, MEM_ADDRESS, MEM_IN} !== 27'd0) begin
            bad++;
            $display("FAIL idle_outputs: got %h want 0", {BUSY, DONE, MEM_LOAD, MEM_ADDRESS, MEM_IN});
        end
    endtask

    task automatic test_copy();
        int  bc, da, ld;
        bit  fz;
        rand_mem();
        exp_mem[8'h10] = 16'hAAAA;
        exp_mem[8'h11] = 16'hBBBB;
        exp_mem[8'h12] = 16'hCCCC;
        load_ram();
        model_copy(8'h10, 8'h80, 3);
        run_xfer(8'h10, 8'h80, 9'd3, 0, 0, bc, da, ld, fz);
        total++;
        if (bc !== 6) begin bad++; $display("FAIL copy_busy_cycles: got %0d want 6", bc); end
        total++;
        if (da !== 7) begin bad++; $display("FAIL copy_done_cycle: got %0d want 7", da); end
        total++;
        if (!fz) begin bad++; $display("FAIL copy_fin_outputs: got nonzero port in FIN want zero"); end
        total++;
        if (rd_q.size() != 3 || rd_q[0] !== 8'h10 || rd_q[1] !== 8'h11 || rd_q[2] !== 8'h12 ||
            wr_q.size() != 3 || wr_q[0] !== 8'h80 || wr_q[1] !== 8'h81 || wr_q[2] !== 8'h82) begin
            bad++;
            $display("FAIL copy_addresses: got reads=%0d writes=%0d want 3/3 at 10.. and 80..",
                     rd_q.size(), wr_q.size());
        end
        total++;
        if ({ram[8'h80], ram[8'h81], ram[8'h82]} !== {16'hAAAA, 16'hBBBB, 16'hCCCC}) begin
            bad++;
            $display("FAIL copy_dest: got %h %h %h want aaaa bbbb cccc", ram[8'h80], ram[8'h81], ram[8'h82]);
        end
        total++;
        if (count_mism() !== 0) begin bad++; $display("FAIL copy_mem: got %0d bad words want 0", count_mism()); end
        @(negedge CLK);
        total++;
        if ({BUSY, DONE} !== 2'b00) begin bad++; $display("FAIL copy_back_idle: got %b want 00", {BUSY, DONE}); end
    endtask

    task automatic test_wrap();
        int          bc, da, ld;
        bit          fz;
        logic [15:0] orig;
        rand_mem();
        load_ram();
        orig = exp_mem[8'hFE];
        model_copy(8'hFE, 8'h01, 4);
        run_xfer(8'hFE, 8'h01, 9'd4, 0, 0, bc, da, ld, fz);
        total++;
        if (rd_q.size() != 4 || rd_q[0] !== 8'hFE || rd_q[1] !== 8'hFF || rd_q[2] !== 8'h00 || rd_q[3] !== 8'h01) begin
            bad++;
            $display("FAIL wrap_reads: got %0d reads first=%h want fe ff 00 01", rd_q.size(), rd_q[0]);
        end
        total++;
        if (ram[8'h04] !== orig) begin bad++; $display("FAIL wrap_word4: got %h want %h", ram[8'h04], orig); end
        total++;
        if (count_mism() !== 0 || da !== 9) begin
            bad++;
            $display("FAIL wrap_mem: got %0d bad words done=%0d want 0 and 9", count_mism(), da);
        end
    endtask

    task automatic test_len_zero();
        int bc, da, ld;
        bit fz;
        run_xfer(8'h33, 8'h44, 9'd0, 0, 0, bc, da, ld, fz);
        total++;
        if (bc !== 0 || ld !== 0) begin bad++; $display("FAIL len0_activity: got busy=%0d loads=%0d want 0/0", bc, ld); end
        total++;
        if (da !== 1) begin bad++; $display("FAIL len0_done: got %0d want 1", da); end
        total++;
        if (count_mism() !== 0) begin bad++; $display("FAIL len0_mem: got %0d bad words want 0", count_mism()); end
    endtask

    task automatic test_back_to_back();
        int bc, da, ld;
        bit fz;
        int stray;
        rand_mem();
        load_ram();
        model_copy(8'h30, 8'h40, 4);
        run_xfer(8'h30, 8'h40, 9'd4, 3, 0, bc, da, ld, fz);
        total++;
        if (da !== 9 || bc !== 8) begin bad++; $display("FAIL busy_start_timing: got done=%0d busy=%0d want 9/8", da, bc); end
        total++;
        if (count_mism() !== 0) begin bad++; $display("FAIL busy_start_mem: got %0d bad words want 0", count_mism()); end
        stray = 0;
        repeat (4) begin
            @(negedge CLK);
            if (BUSY || DONE || MEM_LOAD) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL busy_start_queued: got %0d active cycles want 0", stray); end
        model_copy(8'hC0, 8'h31, 2);
        run_xfer(8'hC0, 8'h31, 9'd2, 0, 0, bc, da, ld, fz);
        model_copy(8'h31, 8'hC1, 3);
        run_xfer(8'h31, 8'hC1, 9'd3, 0, 0, bc, da, ld, fz);
        total++;
        if (count_mism() !== 0 || da !== 7) begin
            bad++;
            $display("FAIL back_to_back: got %0d bad words done=%0d want 0 and 7", count_mism(), da);
        end
    endtask

    task automatic test_abort();
        int bc, da, ld;
        bit fz;
        int seen;
        rand_mem();
        load_ram();
        model_copy(8'h50, 8'h58, 2);
        run_xfer(8'h50, 8'h58, 9'd5, 0, 5, bc, da, ld, fz);
        RESETN = 1'b0;
        #1;
        total++;
        if ({BUSY, DONE, MEM_LOAD, MEM_ADDRESS, MEM_IN} !== 27'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %h want 0", {BUSY, DONE, MEM_LOAD, MEM_ADDRESS, MEM_IN});
        end
        seen = 0;
        repeat (2) begin
            @(negedge CLK);
            if (DONE || BUSY || MEM_LOAD) seen++;
        end
        RESETN = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (DONE || BUSY || MEM_LOAD) seen++;
        end
        total++;
        if (seen !== 0 || da !== 0 || ld !== 2) begin
            bad++;
            $display("FAIL abort_activity: got post=%0d done=%0d loads=%0d want 0/0/2", seen, da, ld);
        end
        total++;
        if (count_mism() !== 0) begin bad++; $display("FAIL abort_mem: got %0d bad words want 0", count_mism()); end
    endtask

    task automatic test_random_copy();
        int          bc, da, ld;
        bit          fz;
        logic [7:0]  s, d;
        int          l;
        rand_mem();
        load_ram();
        for (int i = 0; i < 8; i++) begin
            s = 8'($urandom);
            d = 8'($urandom);
            l = (i == 3) ? 256 : int'($urandom_range(0, 24));
            model_copy(s, d, l);
            run_xfer(s, d, 9'(l), 0, 0, bc, da, ld, fz);
            total++;
            if (da !== 2 * l + 1 || bc !== 2 * l || ld !== l) begin
                bad++;
                $display("FAIL rand_timing[%0d]: got done=%0d busy=%0d loads=%0d want len=%0d", i, da, bc, ld, l);
            end
            total++;
            if (count_mism() !== 0) begin
                bad++;
                $display("FAIL rand_mem[%0d]: got %0d bad words want 0 (src=%h dst=%h len=%0d)", i, count_mism(), s, d, l);
            end
        end
    endtask

`ifdef RAM_DMA_FILL_EN
    task automatic test_fill();
        int          bc, da, ld;
        bit          fz;
        logic [7:0]  d;
        logic [15:0] p;
        int          l;
        rand_mem();
        load_ram();
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'h1234;
        FILL = 1'b1;
        PATTERN = 16'h1234;
        run_xfer(8'h77, 8'h20, 9'd256, 0, 0, bc, da, ld, fz);
        total++;
        if (da !== 257 || bc !== 256 || ld !== 256 || rd_q.size() != 0) begin
            bad++;
            $display("FAIL fill_timing: got done=%0d busy=%0d loads=%0d reads=%0d want 257/256/256/0",
                     da, bc, ld, rd_q.size());
        end
        total++;
        if (count_mism() !== 0) begin bad++; $display("FAIL fill_mem: got %0d bad words want 0", count_mism()); end
        d = 8'($urandom);
        p = 16'($urandom);
        l = int'($urandom_range(1, 30));
        for (int i = 0; i < l; i++) exp_mem[8'(int'(d) + i)] = p;
        PATTERN = p;
        run_xfer(8'($urandom), d, 9'(l), 0, 0, bc, da, ld, fz);
        total++;
        if (count_mism() !== 0 || da !== l + 1) begin
            bad++;
            $display("FAIL fill_rand: got %0d bad words done=%0d want 0 and %0d", count_mism(), da, l + 1);
        end
        FILL = 1'b0;
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        RESETN  = 1'b0;
        START   = 1'b0;
        SRC     = 8'd0;
        DST     = 8'd0;
        LEN     = 9'd0;
`ifdef RAM_DMA_FILL_EN
        FILL    = 1'b0;
        PATTERN = 16'd0;
`endif
        tb_we   = 1'b0;
        tb_addr = 8'd0;
        tb_data = 16'd0;
        test_reset();
        test_copy();
        test_wrap();
        test_len_zero();
        test_back_to_back();
        test_abort();
        test_random_copy();
`ifdef RAM_DMA_FILL_EN
        test_fill();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
